// File: rtl/shadow_ray_dispatcher.sv
`default_nettype none
// shadow_ray_dispatcher: in-order record buffer that sends hit records through occlusion
// traversal, attenuates occluded colours and forwards every record downstream. Rev 1.0
module shadow_ray_dispatcher #(
  parameter int DATA_W       = 512,
  parameter int COLOR_LSB    = 0,
  parameter int CH_W         = 8,
  parameter int DEPTH        = 4,
  parameter int SHADOW_SCALE = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              add_input,
  input  logic [DATA_W-1:0] input_data,
  input  logic              input_hit,
  output logic              fifo_full,
  output logic              trav_strobe,
  output logic [DATA_W-1:0] trav_ray,
  input  logic              trav_busy,
  input  logic              trav_valid,
  input  logic              trav_occluded,
  input  logic              output_fifo_full,
  output logic              valid,
  output logic [DATA_W-1:0] out
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              CW         = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
  localparam logic [CH_W-1:0] SCALE      = CH_W'(SHADOW_SCALE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SHADE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0]  fifo_hit;
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_next;
  logic              push, pop;

  logic [DATA_W-1:0] work, work_next;
  logic [DATA_W-1:0] out_next, trav_ray_next;
  logic              valid_next;
  logic [DATA_W-1:0] shaded;
  logic [3*CH_W-1:0] shaded_color;

  // ---------------- input FIFO ----------------
  assign push       = add_input && !fifo_full;
  assign count_next = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      fifo_full <= (count_next == FULL_COUNT);
    end
  end

  // Storage needs no reset: pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= input_data;
      fifo_hit[wr_ptr]  <= input_hit;
    end
  end

  // ---------------- colour attenuation ----------------
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [2*CH_W-1:0] product;
    logic [CH_W-1:0]   unused_frac;
    assign product = {{CH_W{1'b0}}, work[COLOR_LSB + i*CH_W +: CH_W]} * {{CH_W{1'b0}}, SCALE};
    assign {shaded_color[i*CH_W +: CH_W], unused_frac} = product;
  end

  always_comb begin
    shaded = work;
    shaded[COLOR_LSB +: 3*CH_W] = shaded_color;
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      work     <= '0;
      out      <= '0;
      trav_ray <= '0;
      valid    <= 1'b0;
    end else begin
      state    <= state_next;
      work     <= work_next;
      out      <= out_next;
      trav_ray <= trav_ray_next;
      valid    <= valid_next;
    end
  end

  always_comb begin
    state_next    = state;
    work_next     = work;
    out_next      = out;
    trav_ray_next = trav_ray;
    valid_next    = 1'b0;
    trav_strobe   = 1'b0;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          work_next = fifo_data[rd_ptr];
          if (fifo_hit[rd_ptr]) begin
            trav_ray_next = fifo_data[rd_ptr];
            state_next    = ISSUE;
          end else begin
            state_next = DONE;
          end
        end
      end
      ISSUE: begin
        if (!trav_busy) begin
          trav_strobe = 1'b1;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (trav_valid) state_next = trav_occluded ? SHADE : DONE;
      end
      SHADE: begin
        work_next  = shaded;
        state_next = DONE;
      end
      DONE: begin
        if (!output_fifo_full) begin
          out_next   = work;
          valid_next = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire
